// File: rtl/decode_pkg.sv
// RV32I decode types, opcode constants and the pure decode function shared by decode_stage.
// Optional feature macro: DECODE_RV32M_EN (OP with funct7=0000001 decodes as a legal RV32M op).
package decode_pkg;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [6:0] Fn7Base = 7'b0000000;
  localparam logic [6:0] Fn7Alt  = 7'b0100000;
  localparam logic [6:0] Fn7Mul  = 7'b0000001;

  typedef enum logic [2:0] {
    FmtR       = 3'd0,
    FmtI       = 3'd1,
    FmtS       = 3'd2,
    FmtB       = 3'd3,
    FmtU       = 3'd4,
    FmtJ       = 3'd5,
    FmtIllegal = 3'd6
  } fmt_e;

  // Immediate is kept at 32 bits; every format sign-extends from inst[31], so the
  // consumer widens it to XLEN with a plain signed extension.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  fn3;
    logic [6:0]  fn7;
    fmt_e        fmt;
    logic [31:0] imm;
    logic        illegal;
    logic        is_mul;
  } decoded_t;

  function automatic logic [31:0] imm_fn(fmt_e fmt, logic [31:0] inst);
    logic [31:0] imm;
    imm = '0;
    case (fmt)
      FmtI:    imm = {{20{inst[31]}}, inst[31:20]};
      FmtS:    imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FmtB:    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FmtU:    imm = {inst[31:12], 12'b0};
      FmtJ:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  function automatic decoded_t decode_fn(logic [31:0] inst);
    decoded_t   d;
    logic [2:0] fn3;
    logic [6:0] fn7;
    logic       shift;
    logic       legal;
    logic       is_mul;

    d      = '0;
    fn3    = inst[14:12];
    fn7    = inst[31:25];
    shift  = (fn3 == 3'b001) || (fn3 == 3'b101);
    legal  = 1'b1;
    is_mul = 1'b0;
    d.fmt  = FmtI;

    // Every supported opcode ends in 2'b11, so inst[1:0] != 2'b11 falls into default.
    case (inst[6:0])
      OpLui, OpAuipc: d.fmt = FmtU;
      OpJal:          d.fmt = FmtJ;
      OpJalr:         legal = (fn3 == 3'b000);
      OpBranch: begin
        d.fmt = FmtB;
        legal = (fn3 != 3'b010) && (fn3 != 3'b011);
      end
      OpLoad:         legal = (fn3 != 3'b011) && (fn3 != 3'b110) && (fn3 != 3'b111);
      OpStore: begin
        d.fmt = FmtS;
        legal = (fn3 < 3'b011);
      end
      OpImm:          legal = !shift || (fn7 == Fn7Base) || ((fn7 == Fn7Alt) && (fn3 == 3'b101));
      OpReg: begin
        d.fmt = FmtR;
`ifdef DECODE_RV32M_EN
        is_mul = (fn7 == Fn7Mul);
`else
        is_mul = 1'b0;
`endif
        legal = (fn7 == Fn7Base) || ((fn7 == Fn7Alt) && ((fn3 == 3'b000) || (fn3 == 3'b101)))
                || is_mul;
      end
      default:        legal = 1'b0;
    endcase

    if (!legal) begin
      d         = '0;
      d.fmt     = FmtIllegal;
      d.illegal = 1'b1;
    end else begin
      d.opcode = inst[6:0];
      d.is_mul = is_mul;
      if ((d.fmt != FmtS) && (d.fmt != FmtB)) begin
        d.rd = inst[11:7];
      end
      if ((d.fmt != FmtU) && (d.fmt != FmtJ)) begin
        d.rs1 = inst[19:15];
        d.fn3 = fn3;
      end
      if ((d.fmt == FmtR) || (d.fmt == FmtS) || (d.fmt == FmtB)) begin
        d.rs2 = inst[24:20];
      end
      if ((d.fmt == FmtR) || ((inst[6:0] == OpImm) && shift)) begin
        d.fn7 = fn7;
      end
      d.imm = imm_fn(d.fmt, inst);
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side and register-read-side handshake bundle of decode_stage.
// master: the surrounding pipeline (drives instructions in, accepts records); slave: the stage.
interface decode_if import decode_pkg::*; #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
) ();

  logic            inValid;
  logic            inReady;
  logic [31:0]     inInst;
  logic [PC_W-1:0] inPc;

  logic            outValid;
  logic            outReady;
  logic [31:0]     outInst;
  logic [PC_W-1:0] outPc;
  logic [6:0]      outOpcode;
  logic [4:0]      outRd;
  logic [4:0]      outRs1;
  logic [4:0]      outRs2;
  logic [2:0]      outFn3;
  logic [6:0]      outFn7;
  fmt_e            outFmt;
  logic [XLEN-1:0] outImm;
  logic            outIllegal;
  logic            outIsMul;

  modport master (
    output inValid, inInst, inPc, outReady,
    input  inReady, outValid, outInst, outPc, outOpcode, outRd, outRs1, outRs2,
    input  outFn3, outFn7, outFmt, outImm, outIllegal, outIsMul
  );

  modport slave (
    input  inValid, inInst, inPc, outReady,
    output inReady, outValid, outInst, outPc, outOpcode, outRd, outRs1, outRs2,
    output outFn3, outFn7, outFmt, outImm, outIllegal, outIsMul
  );

endinterface

// File: rtl/decode_fifo.sv
// Count-based valid/ready FIFO with synchronous flush; push_ready is registered so it
// never depends combinationally on the pop side.
module decode_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ready_q, ready_d;
  logic             push;
  logic             pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? ptr_t'(0) : ptr_t'(p + 1'b1);
  endfunction

  assign push       = push_valid && ready_q;
  assign pop_valid  = (count_q != '0);
  assign pop        = pop_valid && pop_ready;
  assign pop_data   = mem_q[rd_ptr_q];
  assign push_ready = ready_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    ready_d = (count_d < CntW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Buffered RV32I decode stage: input FIFO, combinational decode of the FIFO head, registered record.
// Optional feature macro: DECODE_RV32M_EN (handled inside decode_pkg::decode_fn).
module decode_stage import decode_pkg::*; #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 2
) (
  input logic     clk,
  input logic     rstN,
  input logic     flush,
  decode_if.slave bus
);

  localparam int unsigned Width = 32 + PC_W;

  logic             head_valid;
  logic             head_ready;
  logic [Width-1:0] head_data;
  logic [31:0]      head_inst;
  logic [PC_W-1:0]  head_pc;
  decoded_t         head_dec;
  logic             load;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_inst_q, out_inst_d;
  logic [PC_W-1:0]  out_pc_q, out_pc_d;
  decoded_t         out_dec_q, out_dec_d;

  decode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (Width)
  ) u_fifo (
    .clk        (clk),
    .rstN       (rstN),
    .flush      (flush),
    .push_valid (bus.inValid),
    .push_ready (bus.inReady),
    .push_data  ({bus.inInst, bus.inPc}),
    .pop_valid  (head_valid),
    .pop_ready  (head_ready),
    .pop_data   (head_data)
  );

  assign {head_inst, head_pc} = head_data;
  assign head_dec             = decode_fn(head_inst);

  // The output register takes a new record whenever it is empty or being drained.
  assign head_ready = !out_valid_q || bus.outReady;
  assign load       = head_valid && head_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    out_dec_d   = out_dec_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_inst_d  = head_inst;
      out_pc_d    = head_pc;
      out_dec_d   = head_dec;
    end else if (bus.outReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      out_dec_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      out_dec_q   <= out_dec_d;
    end
  end

  assign bus.outValid   = out_valid_q;
  assign bus.outInst    = out_inst_q;
  assign bus.outPc      = out_pc_q;
  assign bus.outOpcode  = out_dec_q.opcode;
  assign bus.outRd      = out_dec_q.rd;
  assign bus.outRs1     = out_dec_q.rs1;
  assign bus.outRs2     = out_dec_q.rs2;
  assign bus.outFn3     = out_dec_q.fn3;
  assign bus.outFn7     = out_dec_q.fn7;
  assign bus.outFmt     = out_dec_q.fmt;
  assign bus.outImm     = XLEN'($signed(out_dec_q.imm));
  assign bus.outIllegal = out_dec_q.illegal;
  // decode_fn only ever sets is_mul when RV32M decoding is compiled in.
  assign bus.outIsMul   = out_dec_q.is_mul;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed cases plus randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_decode_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned DEPTH = 2;

`ifdef DECODE_RV32M_EN
  localparam bit MEn = 1'b1;
`else
  localparam bit MEn = 1'b0;
`endif

  localparam logic [2:0] FR = 3'd0, FI = 3'd1, FS = 3'd2, FB = 3'd3;
  localparam logic [2:0] FU = 3'd4, FJ = 3'd5, FIll = 3'd6;

  typedef struct packed {
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        ill;
    logic        mul;
  } ref_t;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } txn_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic flush = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  txn_t sb_q[$];

  always #5 clk = ~clk;

  decode_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

  decode_stage #(
    .XLEN  (XLEN),
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rstN  (rstN),
    .flush (flush),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference decode built from the instruction-set rules with integer arithmetic.
  function automatic ref_t ref_decode(input logic [31:0] i);
    ref_t       r;
    int         s;
    logic [6:0] op, f7;
    logic [2:0] f3, fmt;
    logic       ok, shift;
    r     = '0;
    s     = $signed(i);
    op    = i[6:0];
    f3    = i[14:12];
    f7    = i[31:25];
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    ok    = 1'b1;
    fmt   = FI;
    case (op)
      7'h37, 7'h17: fmt = FU;
      7'h6f:        fmt = FJ;
      7'h67:        ok = (f3 == 3'd0);
      7'h63: begin fmt = FB; ok = !(f3 inside {3'd2, 3'd3}); end
      7'h03:        ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      7'h23: begin fmt = FS; ok = (f3 <= 3'd2); end
      7'h13:        ok = !shift || (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
      7'h33: begin
        fmt   = FR;
        r.mul = MEn && (f7 == 7'h01);
        ok    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || r.mul;
      end
      default:      ok = 1'b0;
    endcase
    if (!ok) begin
      r     = '0;
      r.fmt = FIll;
      r.ill = 1'b1;
    end else begin
      r.opc = op;
      r.fmt = fmt;
      if (fmt != FS && fmt != FB) r.rd = i[11:7];
      if (fmt != FU && fmt != FJ) begin
        r.rs1 = i[19:15];
        r.f3  = f3;
      end
      if (fmt == FR || fmt == FS || fmt == FB) r.rs2 = i[24:20];
      if (fmt == FR || (op == 7'h13 && shift)) r.f7 = f7;
      case (fmt)
        FI: r.imm = 32'(s >>> 20);
        FS: r.imm = 32'((s >>> 25) * 32 + int'(i[11:7]));
        FB: r.imm = 32'((s >>> 31) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32
                        + int'(i[11:8]) * 2);
        FU: r.imm = i & 32'hFFFF_F000;
        FJ: r.imm = 32'((s >>> 31) * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                        + int'(i[30:21]) * 2);
        default: r.imm = '0;
      endcase
    end
    return r;
  endfunction

  function automatic ref_t mk(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [2:0] fmt, input logic [31:0] imm, input logic ill,
                              input logic mul);
    ref_t r;
    r = '{opc: opc, rd: rd, rs1: rs1, rs2: rs2, f3: f3, f7: f7, fmt: fmt, imm: imm, ill: ill,
          mul: mul};
    return r;
  endfunction

  function automatic ref_t dut_fields();
    ref_t r;
    r = '{opc: bus.outOpcode, rd: bus.outRd, rs1: bus.outRs1, rs2: bus.outRs2, f3: bus.outFn3,
          f7: bus.outFn7, fmt: bus.outFmt, imm: bus.outImm, ill: bus.outIllegal,
          mul: bus.outIsMul};
    return r;
  endfunction

  function automatic logic [159:0] out_snap();
    return 160'({bus.outValid, bus.outInst, bus.outPc, dut_fields()});
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    i = $urandom;
    if ($urandom_range(0, 7) != 0) begin
      case ($urandom_range(0, 10))
        0:       i[6:0] = 7'h37;
        1:       i[6:0] = 7'h17;
        2:       i[6:0] = 7'h6f;
        3:       i[6:0] = 7'h67;
        4:       i[6:0] = 7'h63;
        5:       i[6:0] = 7'h03;
        6:       i[6:0] = 7'h23;
        7, 8:    i[6:0] = 7'h13;
        default: i[6:0] = 7'h33;
      endcase
      case ($urandom_range(0, 3))
        0:       i[31:25] = 7'h00;
        1:       i[31:25] = 7'h20;
        2:       i[31:25] = 7'h01;
        default: i[31:25] = i[31:25];
      endcase
    end
    return i;
  endfunction

  // Monitor: samples mid-cycle, records accepted inputs and checks every consumed record.
  initial begin : monitor
    logic [159:0] prev_snap;
    logic         hold_prev;
    txn_t         t;
    hold_prev = 1'b0;
    prev_snap = '0;
    forever begin
      @(negedge clk);
      if (!rstN || flush) begin
        sb_q.delete();
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) chk("held_stable", out_snap(), prev_snap);
        if (bus.outValid && bus.outReady) begin
          chk("out_expected", 160'(sb_q.size() != 0), 160'(1));
          if (sb_q.size() != 0) begin
            t = sb_q.pop_front();
            chk("passthru", {bus.outInst, bus.outPc}, t);
            chk("fields", dut_fields(), ref_decode(t.inst));
          end
        end
        hold_prev = bus.outValid && !bus.outReady;
        prev_snap = out_snap();
        if (bus.inValid && bus.inReady) sb_q.push_back({bus.inInst, bus.inPc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [PC_W-1:0] pc);
    bit done;
    done        = 1'b0;
    bus.inValid = 1'b1;
    bus.inInst  = inst;
    bus.inPc    = pc;
    for (int k = 0; k < 50 && !done; k++) begin
      done = bus.inReady;
      tick();
    end
    bus.inValid = 1'b0;
    chk("send_accepted", 160'(done), 160'(1));
  endtask

  task automatic wait_out(input string name);
    int k;
    k = 0;
    while (!bus.outValid && k < 20) begin
      tick();
      k++;
    end
    chk({name, "_valid"}, 160'(bus.outValid), 160'(1));
  endtask

  task automatic consume();
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
  endtask

  task automatic fill_stage(input logic [31:0] base_pc, output int acc);
    bit take;
    acc         = 0;
    bus.inValid = 1'b1;
    for (int c = 0; c < DEPTH + 4; c++) begin
      bus.inInst = 32'h0000_0013 | (32'(acc + 1) << 7);
      bus.inPc   = base_pc + 32'(acc * 4);
      take       = bus.inReady;
      tick();
      if (take) acc++;
    end
    bus.inValid = 1'b0;
  endtask

  initial begin : stimulus
    int acc;
    bus.inValid  = 1'b0;
    bus.inInst   = '0;
    bus.inPc     = '0;
    bus.outReady = 1'b0;

    tick();
    tick();
    chk("rst_outputs", out_snap(), '0);
    chk("rst_inReady", 160'(bus.inReady), 160'(1));
    rstN = 1'b1;
    tick();

    // addi x5,x6,-1: one-cycle latency from accept to outValid
    bus.inValid = 1'b1;
    bus.inInst  = 32'hFFF3_0293;
    bus.inPc    = 32'h100;
    tick();
    bus.inValid = 1'b0;
    chk("lat_after_accept", 160'(bus.outValid), 160'(0));
    tick();
    chk("lat_next_edge", 160'(bus.outValid), 160'(1));
    chk("addi", dut_fields(), mk(7'h13, 5, 6, 0, 0, 0, FI, 32'hFFFF_FFFF, 0, 0));
    consume();

    send(32'hFE20_8EE3, 32'h104);
    wait_out("beq");
    chk("beq", dut_fields(), mk(7'h63, 0, 1, 2, 0, 0, FB, 32'hFFFF_FFFC, 0, 0));
    consume();

    send(32'h0000_0000, 32'h108);
    wait_out("zero");
    chk("zero_illegal", dut_fields(), mk(0, 0, 0, 0, 0, 0, FIll, 0, 1, 0));
    consume();

    send(32'h0231_00B3, 32'h10C);
    wait_out("mul");
    chk("mul", dut_fields(), MEn ? mk(7'h33, 1, 2, 3, 0, 7'h01, FR, 0, 0, 1)
                                 : mk(0, 0, 0, 0, 0, 0, FIll, 0, 1, 0));
    consume();

    // Back-pressure: DEPTH in the FIFO plus one held in the output register
    fill_stage(32'h200, acc);
    chk("full_accepts", 160'(acc), 160'(DEPTH + 1));
    chk("full_inReady", 160'(bus.inReady), 160'(0));
    bus.outReady = 1'b1;
    repeat (DEPTH + 3) tick();
    chk("drain_sb_empty", 160'(sb_q.size()), 160'(0));
    chk("drain_outValid", 160'(bus.outValid), 160'(0));
    chk("drain_inReady", 160'(bus.inReady), 160'(1));
    bus.outReady = 1'b0;

    // Flush with a full stage and an offered instruction
    fill_stage(32'h300, acc);
    bus.inValid = 1'b1;
    bus.inInst  = 32'hABCD_EFB7;
    bus.inPc    = 32'h3F0;
    flush       = 1'b1;
    tick();
    flush       = 1'b0;
    bus.inValid = 1'b0;
    chk("flush_full_outValid", 160'(bus.outValid), 160'(0));
    chk("flush_full_inReady", 160'(bus.inReady), 160'(1));
    bus.outReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("flush_full_no_ghost", 160'(bus.outValid), 160'(0));
    end
    bus.outReady = 1'b0;

    // Flush while the FIFO could accept: the offered instruction is still dropped
    send(32'h0010_0093, 32'h400);
    bus.inValid = 1'b1;
    bus.inInst  = 32'hABCD_EFB7;
    bus.inPc    = 32'h404;
    flush       = 1'b1;
    tick();
    flush       = 1'b0;
    bus.inValid = 1'b0;
    chk("flush_open_outValid", 160'(bus.outValid), 160'(0));
    bus.outReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("flush_open_no_ghost", 160'(bus.outValid), 160'(0));
    end
    bus.outReady = 1'b0;

    // Asynchronous reset with records queued
    send(32'h0020_0113, 32'h500);
    send(32'h0030_0193, 32'h504);
    send(32'h0040_0213, 32'h508);
    tick();
    rstN = 1'b0;
    #1;
    chk("midrst_outputs", out_snap(), '0);
    chk("midrst_inReady", 160'(bus.inReady), 160'(1));
    tick();
    tick();
    rstN = 1'b1;
    tick();

    // Randomized traffic with occasional flushes
    for (int c = 0; c < 600; c++) begin
      bus.inValid  = ($urandom_range(0, 3) != 0);
      bus.inInst   = rand_inst();
      bus.inPc     = $urandom;
      bus.outReady = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush        = 1'b0;
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    repeat (DEPTH + 6) tick();
    chk("final_sb_empty", 160'(sb_q.size()), 160'(0));
    chk("final_outValid", 160'(bus.outValid), 160'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
